// File: rtl/wb_arbiter_2to1.sv
// Two-master Wishbone classic arbiter: IBUS (m0, read-only) and DBUS (m1) share one slave.
// Round-robin on ties, one transfer per grant, watchdog forces an ack on a hung slave.
module wb_arbiter_2to1 #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] m0_adr_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        to_clr_i,
    output logic        to_err_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] HIT_VAL = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_err_q, to_err_d;

    logic        req0, req1;
    logic        sel1;
    logic        g_cyc, g_stb;
    logic        ack;
    logic [31:0] rd_dat;
    logic        exit_gnt;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign to_err_o = to_err_q;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = '0;
        to_err_d   = to_clr_i ? 1'b0 : to_err_q;

        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        ack      = 1'b0;
        rd_dat   = '0;
        exit_gnt = 1'b0;

        sel1  = (state_q == GNT1);
        g_cyc = sel1 ? m1_cyc_i : m0_cyc_i;
        g_stb = sel1 ? m1_stb_i : m0_stb_i;

        case (state_q)
            IDLE: begin
                // last_gnt_q == 0 means IBUS was served last, so DBUS wins a tie
                if (req0 && req1) begin
                    state_d = last_gnt_q ? GNT0 : GNT1;
                end else if (req1) begin
                    state_d = GNT1;
                end else if (req0) begin
                    state_d = GNT0;
                end
            end
            GNT0, GNT1: begin
                s_adr_o = sel1 ? m1_adr_i : m0_adr_i;
                s_dat_o = sel1 ? m1_dat_i : 32'h0;
                s_we_o  = sel1 & m1_we_i;
                s_sel_o = sel1 ? m1_sel_i : 4'hF;
                s_cyc_o = g_cyc;
                s_stb_o = g_stb;
                rd_dat  = s_dat_i;
                if (!g_cyc) begin
                    exit_gnt = 1'b1;
                end else if (s_ack_i) begin
                    ack      = 1'b1;
                    exit_gnt = 1'b1;
                end else if ((TIMEOUT > 0) && (cnt_q == HIT_VAL)) begin
                    // Watchdog hit: release the slave and terminate the master cycle with zero data
                    s_cyc_o  = 1'b0;
                    s_stb_o  = 1'b0;
                    ack      = 1'b1;
                    rd_dat   = 32'h0;
                    to_err_d = 1'b1;
                    exit_gnt = 1'b1;
                end else begin
                    cnt_d = (TIMEOUT > 0) ? cnt_q + 1'b1 : '0;
                end
                if (exit_gnt) begin
                    state_d    = IDLE;
                    last_gnt_d = sel1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        m0_ack_o = ack & ~sel1;
        m1_ack_o = ack & sel1;
        m0_dat_o = sel1 ? 32'h0 : rd_dat;
        m1_dat_o = sel1 ? rd_dat : 32'h0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b0;
            cnt_q      <= '0;
            to_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            to_err_q   <= to_err_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Scoreboard bench for wb_arbiter_2to1: a slave model checks slave-side transfers and a
// monitor checks every master ack against queued expectations.
module tb_wb_arbiter_2to1;

    typedef struct {
        bit          m;
        logic [31:0] data;
    } ack_exp_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] rdata;
    } slv_exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] m0_adr_i;
    logic        m0_cyc_i, m0_stb_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic        m1_we_i;
    logic [3:0]  m1_sel_i;
    logic        m1_cyc_i, m1_stb_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_we_o;
    logic [3:0]  s_sel_o;
    logic        s_cyc_o, s_stb_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic        to_clr_i;
    logic        to_err_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ack_exp_t ack_q[$];
    slv_exp_t slv_q[$];

    bit slave_en  = 0;
    int slave_lat = 0;
    int slave_cnt = 0;

    wb_arbiter_2to1 #(.TIMEOUT(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0_adr_i (m0_adr_i),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_we_i  (m1_we_i),
        .m1_sel_i (m1_sel_i),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .to_clr_i (to_clr_i),
        .to_err_o (to_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic pushExp(input bit m, input logic [31:0] adr, input logic [31:0] dat,
                           input logic we, input logic [3:0] sel, input logic [31:0] rdata);
        ack_exp_t a;
        slv_exp_t s;
        a.m = m;
        a.data = rdata;
        ack_q.push_back(a);
        s.adr = adr;
        s.dat = m ? dat : 32'h0;
        s.we = m ? we : 1'b0;
        s.sel = m ? sel : 4'hF;
        s.rdata = rdata;
        slv_q.push_back(s);
    endtask

    task automatic waitAck(input bit m, input bit to, input bit chk_lat, output int cycles);
        bit got;
        got = 0;
        cycles = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            #2;
            cycles++;
            if (chk_lat && cycles == 1) checkOutput("grant_cycle_n_idle", {31'h0, s_cyc_o}, 32'h0);
            if (chk_lat && cycles == 2) checkOutput("grant_cycle_n1_cyc", {31'h0, s_cyc_o}, 32'h1);
            if (m ? m1_ack_o : m0_ack_o) begin
                got = 1;
                if (to) checkOutput("timeout_cyc_low", {31'h0, s_cyc_o}, 32'h0);
            end
        end
        if (!got) checkOutput("ack_wait_bound", 32'h0, 32'h1);
    endtask

    task automatic applyStimulus(input bit m, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic we, input logic [3:0] sel, input bit to,
                                 input bit chk_lat, output int cycles);
        @(posedge clk);
        #1;
        if (m) begin
            m1_adr_i = adr; m1_dat_i = dat; m1_we_i = we; m1_sel_i = sel;
            m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        end else begin
            m0_adr_i = adr; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        end
        waitAck(m, to, chk_lat, cycles);
        @(posedge clk);
        #1;
        if (m) begin
            m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        end else begin
            m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        end
    endtask

    // Slave model: acks slave_lat+1 cycles into a strobe and checks what the arbiter presented
    initial begin
        slv_exp_t e;
        forever begin
            @(negedge clk);
            if (slave_en) begin
                if (s_ack_i) begin
                    s_ack_i = 1'b0;
                    slave_cnt = 0;
                end else if (s_cyc_o && s_stb_o) begin
                    slave_cnt++;
                    if (slave_lat >= 0 && slave_cnt > slave_lat) begin
                        if (slv_q.size() == 0) begin
                            checkOutput("slave_unexpected_xfer", 32'h1, 32'h0);
                        end else begin
                            e = slv_q.pop_front();
                            checkOutput("slave_adr", s_adr_o, e.adr);
                            checkOutput("slave_dat", s_dat_o, e.dat);
                            checkOutput("slave_we", {31'h0, s_we_o}, {31'h0, e.we});
                            checkOutput("slave_sel", {28'h0, s_sel_o}, {28'h0, e.sel});
                            s_dat_i = e.rdata;
                        end
                        s_ack_i = 1'b1;
                    end
                end else begin
                    slave_cnt = 0;
                end
            end
        end
    end

    // Ack monitor: every master ack must match the head of the expectation queue
    initial begin
        ack_exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (m0_ack_o || m1_ack_o) begin
                if (m0_ack_o && m1_ack_o) begin
                    checkOutput("dual_ack", 32'h1, 32'h0);
                end else if (ack_q.size() == 0) begin
                    checkOutput("unexpected_ack", 32'h1, 32'h0);
                end else begin
                    e = ack_q.pop_front();
                    checkOutput("ack_master", {31'h0, m1_ack_o}, {31'h0, e.m});
                    checkOutput("ack_data", m1_ack_o ? m1_dat_o : m0_dat_o, e.data);
                    checkOutput("other_master_dat", m1_ack_o ? m0_dat_o : m1_dat_o, 32'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int c0, c1, cyc;
        bit got;
        rst = 1'b1;
        m0_adr_i = '0; m0_cyc_i = 0; m0_stb_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 0; m1_sel_i = '0; m1_cyc_i = 0; m1_stb_i = 0;
        s_dat_i = '0; s_ack_i = 0; to_clr_i = 0;

        repeat (2) @(negedge clk);
        #2;
        checkOutput("rst_s_cyc", {31'h0, s_cyc_o}, 32'h0);
        checkOutput("rst_s_stb", {31'h0, s_stb_o}, 32'h0);
        checkOutput("rst_s_adr", s_adr_o, 32'h0);
        checkOutput("rst_s_sel", {28'h0, s_sel_o}, 32'h0);
        checkOutput("rst_to_err", {31'h0, to_err_o}, 32'h0);
        @(posedge clk); #1; rst = 1'b0;

        $display("[TB] stray slave ack in idle");
        @(posedge clk); #1; s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
        @(negedge clk); #2;
        checkOutput("stray_m0_ack", {31'h0, m0_ack_o}, 32'h0);
        checkOutput("stray_m1_ack", {31'h0, m1_ack_o}, 32'h0);
        checkOutput("stray_m0_dat", m0_dat_o, 32'h0);
        checkOutput("stray_s_cyc", {31'h0, s_cyc_o}, 32'h0);
        @(posedge clk); #1; s_ack_i = 1'b0; slave_en = 1;

        $display("[TB] IBUS read with two-cycle slave wait");
        slave_lat = 2;
        pushExp(0, 32'h0000_0100, 32'h0, 1'b0, 4'h0, 32'h1234_5678);
        applyStimulus(0, 32'h0000_0100, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, cyc);
        checkOutput("m0_ack_cycle", cyc, 32'd4);
        @(negedge clk); #2;
        checkOutput("idle_after_ack", {31'h0, s_cyc_o}, 32'h0);

        $display("[TB] tie after reset: DBUS first");
        slave_lat = 0;
        pushExp(1, 32'h0000_2000, 32'hCAFE_BABE, 1'b1, 4'h3, 32'hAAAA_0001);
        pushExp(0, 32'h0000_3000, 32'h0, 1'b0, 4'h0, 32'h5566_7788);
        fork
            applyStimulus(1, 32'h0000_2000, 32'hCAFE_BABE, 1'b1, 4'h3, 1'b0, 1'b0, c1);
            applyStimulus(0, 32'h0000_3000, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, c0);
        join

        $display("[TB] DBUS alone, then tie goes to IBUS");
        pushExp(1, 32'h0000_4000, 32'h0, 1'b0, 4'hF, 32'h1111_0000);
        applyStimulus(1, 32'h0000_4000, 32'h0, 1'b0, 4'hF, 1'b0, 1'b1, cyc);
        pushExp(0, 32'h0000_4100, 32'h0, 1'b0, 4'h0, 32'h2222_0000);
        pushExp(1, 32'h0000_4200, 32'h3333_4444, 1'b1, 4'hC, 32'h0);
        fork
            applyStimulus(0, 32'h0000_4100, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, c0);
            applyStimulus(1, 32'h0000_4200, 32'h3333_4444, 1'b1, 4'hC, 1'b0, 1'b0, c1);
        join

        $display("[TB] watchdog on hung DBUS read");
        slave_lat = -1;
        begin
            ack_exp_t a;
            a.m = 1; a.data = 32'h0;
            ack_q.push_back(a);
        end
        applyStimulus(1, 32'h0000_5000, 32'h0, 1'b0, 4'hF, 1'b1, 1'b0, cyc);
        checkOutput("timeout_ack_cycle", cyc, 32'd9);
        @(negedge clk); #2;
        checkOutput("to_err_set", {31'h0, to_err_o}, 32'h1);
        repeat (2) @(negedge clk);
        #2;
        checkOutput("to_err_sticky", {31'h0, to_err_o}, 32'h1);
        @(posedge clk); #1; to_clr_i = 1'b1;
        @(posedge clk); #1; to_clr_i = 1'b0;
        @(negedge clk); #2;
        checkOutput("to_err_cleared", {31'h0, to_err_o}, 32'h0);
        slave_lat = 1;
        pushExp(0, 32'h0000_0600, 32'h0, 1'b0, 4'h0, 32'h0BAD_F00D);
        applyStimulus(0, 32'h0000_0600, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, cyc);
        checkOutput("to_err_after_normal", {31'h0, to_err_o}, 32'h0);

        $display("[TB] DBUS abort, IBUS granted afterwards");
        slave_lat = -1;
        @(posedge clk); #1;
        m1_adr_i = 32'h0000_7000; m1_we_i = 1'b0; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checkOutput("abort_granted", {31'h0, s_cyc_o}, 32'h1);
        @(posedge clk); #1;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        m0_adr_i = 32'h0000_0700; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        @(negedge clk); #2;
        checkOutput("abort_s_cyc", {31'h0, s_cyc_o}, 32'h0);
        checkOutput("abort_no_ack", {31'h0, m1_ack_o}, 32'h0);
        @(negedge clk); #2;
        checkOutput("abort_idle", {31'h0, s_cyc_o}, 32'h0);
        @(negedge clk); #2;
        checkOutput("abort_next_grant", {31'h0, s_cyc_o}, 32'h1);
        checkOutput("abort_next_adr", s_adr_o, 32'h0000_0700);
        pushExp(0, 32'h0000_0700, 32'h0, 1'b0, 4'h0, 32'h7777_0700);
        slave_lat = 1;
        waitAck(0, 1'b0, 1'b0, cyc);
        @(posedge clk); #1; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;

        $display("[TB] async reset during IBUS grant");
        slave_lat = -1;
        @(posedge clk); #1;
        m0_adr_i = 32'h0000_0800; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checkOutput("rst_mid_granted", {31'h0, s_cyc_o}, 32'h1);
        #1; rst = 1'b1;
        #1;
        checkOutput("rst_mid_cyc_low", {31'h0, s_cyc_o}, 32'h0);
        checkOutput("rst_mid_no_ack", {31'h0, m0_ack_o}, 32'h0);
        pushExp(0, 32'h0000_0800, 32'h0, 1'b0, 4'h0, 32'h8888_0800);
        slave_lat = 1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); #2;
        checkOutput("rst_release_idle", {31'h0, s_cyc_o}, 32'h0);
        @(negedge clk); #2;
        checkOutput("rst_regrant", {31'h0, s_cyc_o}, 32'h1);
        waitAck(0, 1'b0, 1'b0, cyc);
        @(posedge clk); #1; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;

        repeat (4) @(negedge clk);
        #2;
        got = (ack_q.size() == 0);
        checkOutput("ack_queue_drained", {31'h0, got}, 32'h1);
        got = (slv_q.size() == 0);
        checkOutput("slave_queue_drained", {31'h0, got}, 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
